// File: rtl/dmem_responder.sv
`default_nettype none
// =============================================================================
// Module  : dmem_responder
// Brief   : MEM-stage word load/store responder with a FIFO write buffer
//           draining into a multi-cycle backing array. Optional macro
//           DMEM_RAW_FWD_EN enables store-to-load forwarding from the buffer.
// Revision: 1.0 - initial release
// =============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int WB_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        memRead,
    input  logic                        memWrite,
    input  logic [31:0]                 address,
    input  logic [31:0]                 writeData,
    output logic [31:0]                 readData,
    output logic                        memStall,
    output logic                        busErr,
    output logic [$clog2(WB_DEPTH):0]   wbCount
);

    localparam int C_AW = $clog2(DEPTH_WORDS);
    localparam int C_PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int C_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int C_NW = $clog2(WB_DEPTH) + 1;
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(LATENCY - 1);
    localparam logic [C_NW-1:0] C_FULL     = C_NW'(WB_DEPTH);
    localparam logic [C_PW-1:0] C_PTR_LAST = C_PW'(WB_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [C_CW-1:0]   cnt_q, cnt_d;
    logic [C_PW-1:0]   head_q, head_d;
    logic [C_PW-1:0]   tail_q, tail_d;
    logic [C_NW-1:0]   count_q, count_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              bus_err_q, bus_err_d;

    // Array and buffer storage carry no reset; validity comes from the pointers.
    logic [31:0]       mem_q     [DEPTH_WORDS];
    logic [C_AW-1:0]   wb_addr_q [WB_DEPTH];
    logic [31:0]       wb_data_q [WB_DEPTH];

    logic              w_illegal;
    logic              w_load_req;
    logic              w_store_req;
    logic [C_AW-1:0]   w_idx;
    logic              w_last;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_hit;
    logic              w_fwd_hit;
    logic              w_read_done;
    logic              w_stall;
    logic              w_rd_valid;
    logic [31:0]       w_rd_data;
    logic              unused_addr_bits;
`ifdef DMEM_RAW_FWD_EN
    logic [31:0]       w_fwd_data;
`endif

    assign w_idx            = address[C_AW+1:2];
    assign unused_addr_bits = ^address[31:C_AW+2];
    assign w_illegal   = (memRead | memWrite) & ((address[1:0] != 2'b00) | (memRead & memWrite));
    assign w_load_req  = memRead  & ~w_illegal;
    assign w_store_req = memWrite & ~w_illegal;
    assign w_last      = (cnt_q == C_CNT_LAST);
    assign w_pop       = (state_q == S_DRAIN) & w_last;
    assign w_read_done = (state_q == S_READ) & w_last;
    assign w_full      = (count_q == C_FULL);
    assign w_push      = w_store_req & (~w_full | w_pop);

    // Walk oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        w_hit = 1'b0;
`ifdef DMEM_RAW_FWD_EN
        w_fwd_data = '0;
`endif
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((C_NW'(i) < count_q) &&
                (wb_addr_q[C_PW'((int'(head_q) + i) % WB_DEPTH)] == w_idx)) begin
                w_hit = 1'b1;
`ifdef DMEM_RAW_FWD_EN
                w_fwd_data = wb_data_q[C_PW'((int'(head_q) + i) % WB_DEPTH)];
`endif
            end
        end
    end

`ifdef DMEM_RAW_FWD_EN
    assign w_fwd_hit = w_load_req & w_hit;
`else
    assign w_fwd_hit = 1'b0;
`endif

    always_comb begin
        w_rd_valid = w_read_done;
        w_rd_data  = mem_q[w_idx];
`ifdef DMEM_RAW_FWD_EN
        if (w_fwd_hit) begin
            w_rd_valid = 1'b1;
            w_rd_data  = w_fwd_data;
        end
`endif
    end

    always_comb begin
        w_stall = 1'b0;
        if (w_store_req) begin
            w_stall = ~w_push;
        end else if (w_load_req) begin
            w_stall = ~(w_fwd_hit | w_read_done);
        end
    end

    // A buffer hit without forwarding sends IDLE to DRAIN, which drains ahead of the load.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (w_load_req && !w_hit) begin
                    state_d = S_READ;
                end else if ((count_q != '0) || w_push) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + C_CW'(1);
                end
            end
            S_READ: begin
                if (w_last) begin
                    state_d = (count_q != '0) ? S_DRAIN : S_IDLE;
                end else begin
                    cnt_d = cnt_q + C_CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + C_NW'(w_push) - C_NW'(w_pop);
        read_data_d = w_rd_valid ? w_rd_data : read_data_q;
        bus_err_d   = w_illegal;
        if (w_pop) begin
            head_d = (head_q == C_PTR_LAST) ? '0 : head_q + C_PW'(1);
        end
        if (w_push) begin
            tail_d = (tail_q == C_PTR_LAST) ? '0 : tail_q + C_PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // The array commits only at the final drain edge, so a reset mid-drain leaves it intact.
    always_ff @(posedge clk) begin
        if (w_push) begin
            wb_addr_q[tail_q] <= w_idx;
            wb_data_q[tail_q] <= writeData;
        end
        if (w_pop) begin
            mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
        end
    end

    assign readData = w_rd_valid ? w_rd_data : read_data_q;
    assign memStall = rst_n & w_stall;
    assign busErr   = bus_err_q;
    assign wbCount  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// =============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed self-checking bench for dmem_responder (LATENCY=2, WB_DEPTH=4).
// Revision: 1.0 - initial release
// =============================================================================
module tb_dmem_responder;

`ifdef DMEM_RAW_FWD_EN
    localparam int C_RAW_STALLS   = 0;
    localparam int C_YOUNG_STALLS = 0;
`else
    localparam int C_RAW_STALLS   = 4;
    localparam int C_YOUNG_STALLS = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        memStall;
    logic        busErr;
    logic [2:0]  wbCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2),
        .WB_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .memStall  (memStall),
        .busErr    (busErr),
        .wbCount   (wbCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            output int stalls, output logic [31:0] cnt_acc);
        bit done;
        done    = 1'b0;
        stalls  = 0;
        cnt_acc = '0;
        memWrite  = 1'b1;
        address   = a;
        writeData = d;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!memStall) begin
                done    = 1'b1;
                cnt_acc = 32'(wbCount);
            end else begin
                stalls++;
            end
            next_cycle();
        end
        memWrite = 1'b0;
        check("store_accepted", 32'(done), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] data, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        data   = '0;
        memRead = 1'b1;
        address = a;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!memStall) begin
                done = 1'b1;
                data = readData;
            end else begin
                stalls++;
            end
            next_cycle();
        end
        memRead = 1'b0;
        check("load_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (wbCount == 3'd0) done = 1'b1;
            next_cycle();
        end
        check("drain_complete", 32'(done), 32'd1);
        next_cycle();
    endtask

    task automatic illegal_cycle(input string tag, input logic rd, input logic [31:0] a,
                                 input logic [31:0] d);
        memRead   = rd;
        memWrite  = 1'b1;
        address   = a;
        writeData = d;
        @(negedge clk);
        check({tag, "_stall"}, 32'(memStall), 32'd0);
        next_cycle();
        memRead  = 1'b0;
        memWrite = 1'b0;
        @(negedge clk);
        check({tag, "_buserr"}, 32'(busErr), 32'd1);
        check({tag, "_wbcount"}, 32'(wbCount), 32'd0);
        next_cycle();
        @(negedge clk);
        check({tag, "_buserr_clr"}, 32'(busErr), 32'd0);
        next_cycle();
    endtask

    initial begin
        logic [31:0] data;
        logic [31:0] cnt;
        int          stalls;

        rst_n     = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        #12;
        check("rst_readdata", readData, 32'd0);
        check("rst_stall",    32'(memStall), 32'd0);
        check("rst_buserr",   32'(busErr), 32'd0);
        check("rst_wbcount",  32'(wbCount), 32'd0);
        #10 rst_n = 1'b1;
        next_cycle();

        // Preload 0x40 through the buffer, then a clean load miss.
        do_store(32'h40, 32'h1234_5678, stalls, cnt);
        @(negedge clk);
        check("preload_wbcount", 32'(wbCount), 32'd1);
        next_cycle();
        wait_empty();
        do_load(32'h40, data, stalls);
        check("miss_stalls", 32'(stalls), 32'd2);
        check("miss_data",   data, 32'h1234_5678);
        @(negedge clk);
        check("miss_data_held", readData, 32'h1234_5678);
        next_cycle();

        // Read-after-write in the very next cycle.
        do_store(32'h10, 32'hDEAD_BEEF, stalls, cnt);
        do_load(32'h10, data, stalls);
        check("raw_stalls", 32'(stalls), 32'(C_RAW_STALLS));
        check("raw_data",   data, 32'hDEAD_BEEF);
        wait_empty();

        // Misaligned store aliasing word 0x10 must leave it untouched.
        illegal_cycle("ill_misalign", 1'b0, 32'h13, 32'hBAD0_BAD0);
        do_load(32'h10, data, stalls);
        check("ill_misalign_array", data, 32'hDEAD_BEEF);

        // Youngest buffered store to the same word wins.
        do_store(32'h20, 32'd1, stalls, cnt);
        do_store(32'h20, 32'd2, stalls, cnt);
        do_load(32'h20, data, stalls);
        check("young_stalls", 32'(stalls), 32'(C_YOUNG_STALLS));
        check("young_data",   data, 32'd2);
        wait_empty();
        do_load(32'h20, data, stalls);
        check("young_array", data, 32'd2);

        illegal_cycle("ill_rdwr", 1'b1, 32'h20, 32'h0000_55AA);
        do_load(32'h20, data, stalls);
        check("ill_rdwr_array", data, 32'd2);
        wait_empty();

        // Back-to-back stores: buffer fills to 4, last store waits for a pop.
        for (int i = 0; i < 7; i++) begin
            do_store(32'(4 * i), 32'hA0 + 32'(i), stalls, cnt);
            if (i == 4) check("full_s4_stalls", 32'(stalls), 32'd0);
            if (i == 5) check("full_s5_count",  cnt, 32'd4);
            if (i == 6) begin
                check("full_s6_stalls", 32'(stalls), 32'd2);
                check("full_s6_count",  cnt, 32'd4);
            end
        end
        @(negedge clk);
        check("full_after_count", 32'(wbCount), 32'd4);
        next_cycle();
        wait_empty();
        do_load(32'h10, data, stalls);
        check("full_word4", data, 32'hA4);

        // Reset while the second of four stores is being drained.
        for (int i = 0; i < 4; i++) begin
            do_store(32'(4 * i), 32'hF0 + 32'(i), stalls, cnt);
        end
        check("rstmid_pre_count", 32'(wbCount), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_wbcount",  32'(wbCount), 32'd0);
        check("rstmid_stall",    32'(memStall), 32'd0);
        check("rstmid_readdata", readData, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        next_cycle();
        do_load(32'h04, data, stalls);
        check("rstmid_word1_kept", data, 32'hA1);
        do_load(32'h08, data, stalls);
        check("rstmid_word2_kept", data, 32'hA2);
        do_load(32'h00, data, stalls);
        check("rstmid_word0_done", data, 32'hF0);
        check("rstmid_end_count", 32'(wbCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
